// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Purpose  : Filters MMCM lock, releases ordered active-low resets, tracks
//             lock loss. Optional LOCK_LOSS_COUNTER_EN adds lock_loss_count.
//  Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int NUM_STAGES         = 3,
    parameter int LOCK_FILTER_CYCLES = 1024,
    parameter int STAGE_DELAY_CYCLES = 256,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    input  logic                  sw_reset_req,
    input  logic                  clear_sticky,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  all_up,
    output logic                  lock_lost_sticky,
    output logic [2:0]            fsm_state
`ifdef LOCK_LOSS_COUNTER_EN
    ,
    output logic [15:0]           lock_loss_count
`endif
);

    localparam int c_FILT_W = $clog2(LOCK_FILTER_CYCLES + 1);
    localparam int c_DLY_W  = $clog2(STAGE_DELAY_CYCLES + 1);
    localparam int c_IDX_W  = $clog2(NUM_STAGES + 1);

    localparam logic [c_FILT_W-1:0]   c_FILT_LAST   = c_FILT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [c_FILT_W-1:0]   c_FILT_MAX    = c_FILT_W'(LOCK_FILTER_CYCLES);
    localparam logic [c_DLY_W-1:0]    c_DLY_LAST    = c_DLY_W'(STAGE_DELAY_CYCLES - 1);
    localparam logic [c_DLY_W-1:0]    c_DLY_MAX     = c_DLY_W'(STAGE_DELAY_CYCLES);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST    = c_IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] c_STAGE_FIRST = NUM_STAGES'(1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_FILTER  = 3'd1;
    localparam logic [2:0] c_RELEASE = 3'd2;
    localparam logic [2:0] c_RUN     = 3'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [c_FILT_W-1:0]    r_filt_cnt;
    logic [c_DLY_W-1:0]     r_dly_cnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [NUM_STAGES-1:0]  r_stage_rst_n;
    logic                   r_all_up;
    logic                   r_sticky;

    logic                   w_lock_s;
    logic [2:0]             w_state_nxt;
    logic [c_FILT_W-1:0]    w_filt_nxt;
    logic [c_DLY_W-1:0]     w_dly_nxt;
    logic [c_IDX_W-1:0]     w_idx_nxt;
    logic [c_IDX_W-1:0]     w_idx_inc;
    logic [NUM_STAGES-1:0]  w_stage_nxt;
    logic                   w_all_up_nxt;
    logic                   w_loss_evt;

    assign w_lock_s  = r_sync[SYNC_STAGES-1];
    assign w_idx_inc = r_idx + c_IDX_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_filt_nxt   = r_filt_cnt;
        w_dly_nxt    = r_dly_cnt;
        w_idx_nxt    = r_idx;
        w_stage_nxt  = r_stage_rst_n;
        w_all_up_nxt = 1'b0;
        w_loss_evt   = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_filt_nxt  = '0;
                w_dly_nxt   = '0;
                w_idx_nxt   = '0;
                w_stage_nxt = '0;
                if (w_lock_s) w_state_nxt = c_FILTER;
            end
            c_FILTER: begin
                w_dly_nxt   = '0;
                w_idx_nxt   = '0;
                w_stage_nxt = '0;
                if (!w_lock_s) begin
                    w_state_nxt = c_IDLE;
                    w_filt_nxt  = '0;
                end else if (r_filt_cnt == c_FILT_LAST) begin
                    // A single-stage build has nothing left to sequence after bit 0.
                    w_state_nxt = (NUM_STAGES == 1) ? c_RUN : c_RELEASE;
                    w_filt_nxt  = '0;
                    w_stage_nxt = c_STAGE_FIRST;
                end else if (r_filt_cnt != c_FILT_MAX) begin
                    w_filt_nxt = r_filt_cnt + c_FILT_W'(1);
                end
            end
            c_RELEASE, c_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = c_IDLE;
                    w_loss_evt  = 1'b1;
                    w_filt_nxt  = '0;
                    w_dly_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_stage_nxt = '0;
                end else if (sw_reset_req) begin
                    w_state_nxt = c_FILTER;
                    w_filt_nxt  = '0;
                    w_dly_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_stage_nxt = '0;
                end else if (r_state == c_RUN) begin
                    w_all_up_nxt = 1'b1;
                end else if (r_dly_cnt == c_DLY_LAST) begin
                    w_dly_nxt   = '0;
                    w_idx_nxt   = w_idx_inc;
                    w_stage_nxt = r_stage_rst_n | (c_STAGE_FIRST << w_idx_inc);
                    if (w_idx_inc == c_IDX_LAST) w_state_nxt = c_RUN;
                end else if (r_dly_cnt != c_DLY_MAX) begin
                    w_dly_nxt = r_dly_cnt + c_DLY_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_filt_nxt  = '0;
                w_dly_nxt   = '0;
                w_idx_nxt   = '0;
                w_stage_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync        <= '0;
            r_state       <= c_IDLE;
            r_filt_cnt    <= '0;
            r_dly_cnt     <= '0;
            r_idx         <= '0;
            r_stage_rst_n <= '0;
            r_all_up      <= 1'b0;
            r_sticky      <= 1'b0;
        end else begin
            r_sync        <= {r_sync[SYNC_STAGES-2:0], pll_lock};
            r_state       <= w_state_nxt;
            r_filt_cnt    <= w_filt_nxt;
            r_dly_cnt     <= w_dly_nxt;
            r_idx         <= w_idx_nxt;
            r_stage_rst_n <= w_stage_nxt;
            r_all_up      <= w_all_up_nxt;
            // A loss event coinciding with a clear must not be lost.
            if (w_loss_evt)        r_sticky <= 1'b1;
            else if (clear_sticky) r_sticky <= 1'b0;
        end
    end

`ifdef LOCK_LOSS_COUNTER_EN
    logic [15:0] r_loss_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_evt) begin
            if (clear_sticky)              r_loss_cnt <= 16'd1;
            else if (r_loss_cnt != 16'hFFFF) r_loss_cnt <= r_loss_cnt + 16'd1;
        end else if (clear_sticky) begin
            r_loss_cnt <= '0;
        end
    end

    assign lock_loss_count = r_loss_cnt;
`endif

    assign stage_rst_n      = r_stage_rst_n;
    assign all_up           = r_all_up;
    assign lock_lost_sticky = r_sticky;
    assign fsm_state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_reset_sequencer
//  Purpose  : Scoreboard bench for reset_sequencer (16/4/3/2 configuration).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int NS  = 3;
    localparam int LFC = 16;
    localparam int SDC = 4;
    localparam int SS  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pll_lock;
    logic          sw_reset_req;
    logic          clear_sticky;
    logic [NS-1:0] stage_rst_n;
    logic          all_up;
    logic          lock_lost_sticky;
    logic [2:0]    fsm_state;
`ifdef LOCK_LOSS_COUNTER_EN
    logic [15:0]   lock_loss_count;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         k;
        logic [2:0] stg;
        logic       up;
        logic       sticky;
        logic [2:0] st;
        int         cnt;
        string      name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES         (NS),
        .LOCK_FILTER_CYCLES (LFC),
        .STAGE_DELAY_CYCLES (SDC),
        .SYNC_STAGES        (SS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pll_lock         (pll_lock),
        .sw_reset_req     (sw_reset_req),
        .clear_sticky     (clear_sticky),
        .stage_rst_n      (stage_rst_n),
        .all_up           (all_up),
        .lock_lost_sticky (lock_lost_sticky),
        .fsm_state        (fsm_state)
`ifdef LOCK_LOSS_COUNTER_EN
        ,
        .lock_loss_count  (lock_loss_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_exp(input int k, input logic [2:0] stg, input logic up,
                                     input logic sticky, input logic [2:0] st, input int cnt,
                                     input string name);
        exp_t e;
        e.k = k; e.stg = stg; e.up = up; e.sticky = sticky; e.st = st; e.cnt = cnt; e.name = name;
        sb.push_back(e);
    endfunction

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; pll_lock = 1'b0; sw_reset_req = 1'b0; clear_sticky = 1'b0;
        push_exp(1, 3'b000, 0, 0, 3'd0, 0, "reset_k1");
        push_exp(2, 3'b000, 0, 0, 3'd0, 0, "reset_k2");
        push_exp(4, 3'b000, 0, 0, 3'd0, 0, "idle_after_reset_k4");
        push_exp(5, 3'b000, 0, 0, 3'd0, 0, "idle_after_reset_k5");
        for (int k = 1; k <= 5; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].k <= k) begin
                e = sb.pop_front();
                tests++;
                if (e.k != k || {stage_rst_n, all_up, lock_lost_sticky, fsm_state} !== {e.stg, e.up, e.sticky, e.st}) begin
                    fails++;
                    $display("FAIL %s @%0d: got stage=%b up=%b sticky=%b state=%0d, want stage=%b up=%b sticky=%b state=%0d",
                             e.name, k, stage_rst_n, all_up, lock_lost_sticky, fsm_state, e.stg, e.up, e.sticky, e.st);
                end
`ifdef LOCK_LOSS_COUNTER_EN
                tests++;
                if (lock_loss_count !== e.cnt[15:0]) begin
                    fails++;
                    $display("FAIL %s_count @%0d: got %0d, want %0d", e.name, k, lock_loss_count, e.cnt);
                end
`endif
            end
            if (k == 2) rst_n = 1'b1;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL reset_timeout: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_bringup();
        exp_t e;
        pll_lock = 1'b1;
        push_exp(2,  3'b000, 0, 0, 3'd0, 0, "bringup_idle_k2");
        push_exp(3,  3'b000, 0, 0, 3'd1, 0, "bringup_filter_k3");
        push_exp(18, 3'b000, 0, 0, 3'd1, 0, "bringup_filter_k18");
        push_exp(19, 3'b001, 0, 0, 3'd2, 0, "bringup_stage0_k19");
        push_exp(22, 3'b001, 0, 0, 3'd2, 0, "bringup_hold_k22");
        push_exp(23, 3'b011, 0, 0, 3'd2, 0, "bringup_stage1_k23");
        push_exp(26, 3'b011, 0, 0, 3'd2, 0, "bringup_hold_k26");
        push_exp(27, 3'b111, 0, 0, 3'd3, 0, "bringup_stage2_k27");
        push_exp(28, 3'b111, 1, 0, 3'd3, 0, "bringup_allup_k28");
        push_exp(40, 3'b111, 1, 0, 3'd3, 0, "bringup_run_k40");
        for (int k = 1; k <= 40; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].k <= k) begin
                e = sb.pop_front();
                tests++;
                if (e.k != k || {stage_rst_n, all_up, lock_lost_sticky, fsm_state} !== {e.stg, e.up, e.sticky, e.st}) begin
                    fails++;
                    $display("FAIL %s @%0d: got stage=%b up=%b sticky=%b state=%0d, want stage=%b up=%b sticky=%b state=%0d",
                             e.name, k, stage_rst_n, all_up, lock_lost_sticky, fsm_state, e.stg, e.up, e.sticky, e.st);
                end
`ifdef LOCK_LOSS_COUNTER_EN
                tests++;
                if (lock_loss_count !== e.cnt[15:0]) begin
                    fails++;
                    $display("FAIL %s_count @%0d: got %0d, want %0d", e.name, k, lock_loss_count, e.cnt);
                end
`endif
            end
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL bringup_timeout: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_sw_reset();
        exp_t e;
        sw_reset_req = 1'b1;
        push_exp(1,  3'b000, 0, 0, 3'd1, 0, "swrst_next_cycle");
        push_exp(16, 3'b000, 0, 0, 3'd1, 0, "swrst_filter_k16");
        push_exp(17, 3'b001, 0, 0, 3'd2, 0, "swrst_stage0_k17");
        push_exp(21, 3'b011, 0, 0, 3'd2, 0, "swrst_stage1_k21");
        push_exp(25, 3'b111, 0, 0, 3'd3, 0, "swrst_stage2_k25");
        push_exp(26, 3'b111, 1, 0, 3'd3, 0, "swrst_allup_k26");
        for (int k = 1; k <= 30; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].k <= k) begin
                e = sb.pop_front();
                tests++;
                if (e.k != k || {stage_rst_n, all_up, lock_lost_sticky, fsm_state} !== {e.stg, e.up, e.sticky, e.st}) begin
                    fails++;
                    $display("FAIL %s @%0d: got stage=%b up=%b sticky=%b state=%0d, want stage=%b up=%b sticky=%b state=%0d",
                             e.name, k, stage_rst_n, all_up, lock_lost_sticky, fsm_state, e.stg, e.up, e.sticky, e.st);
                end
`ifdef LOCK_LOSS_COUNTER_EN
                tests++;
                if (lock_loss_count !== e.cnt[15:0]) begin
                    fails++;
                    $display("FAIL %s_count @%0d: got %0d, want %0d", e.name, k, lock_loss_count, e.cnt);
                end
`endif
            end
            if (k == 1) sw_reset_req = 1'b0;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL swrst_timeout: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_lock_loss();
        exp_t e;
        pll_lock = 1'b0;
        push_exp(2, 3'b111, 1, 0, 3'd3, 0, "loss_before_k2");
        push_exp(3, 3'b000, 0, 1, 3'd0, 1, "loss_drop_k3");
        for (int k = 1; k <= 45; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].k <= k) begin
                e = sb.pop_front();
                tests++;
                if (e.k != k || {stage_rst_n, all_up, lock_lost_sticky, fsm_state} !== {e.stg, e.up, e.sticky, e.st}) begin
                    fails++;
                    $display("FAIL %s @%0d: got stage=%b up=%b sticky=%b state=%0d, want stage=%b up=%b sticky=%b state=%0d",
                             e.name, k, stage_rst_n, all_up, lock_lost_sticky, fsm_state, e.stg, e.up, e.sticky, e.st);
                end
`ifdef LOCK_LOSS_COUNTER_EN
                tests++;
                if (lock_loss_count !== e.cnt[15:0]) begin
                    fails++;
                    $display("FAIL %s_count @%0d: got %0d, want %0d", e.name, k, lock_loss_count, e.cnt);
                end
`endif
            end
            if (k == 6) begin
                pll_lock = 1'b1;
                push_exp(8,  3'b000, 0, 1, 3'd0, 1, "relock_idle_k8");
                push_exp(24, 3'b000, 0, 1, 3'd1, 1, "relock_filter_k24");
                push_exp(25, 3'b001, 0, 1, 3'd2, 1, "relock_stage0_k25");
                push_exp(33, 3'b111, 0, 1, 3'd3, 1, "relock_run_k33");
                push_exp(34, 3'b111, 1, 1, 3'd3, 1, "relock_allup_k34");
                push_exp(39, 3'b111, 1, 1, 3'd3, 1, "relock_sticky_held");
            end
            if (k == 40) begin
                clear_sticky = 1'b1;
                push_exp(41, 3'b111, 1, 0, 3'd3, 0, "clear_sticky");
            end
            if (k == 41) clear_sticky = 1'b0;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL loss_timeout: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_chatter();
        exp_t e;
        rst_n = 1'b0; pll_lock = 1'b0;
        push_exp(1,  3'b000, 0, 0, 3'd0, 0, "chatter_reset");
        push_exp(7,  3'b000, 0, 0, 3'd1, 0, "chatter_filter_k7");
        push_exp(16, 3'b000, 0, 0, 3'd1, 0, "chatter_filter_k16");
        push_exp(17, 3'b000, 0, 0, 3'd0, 0, "chatter_back_idle");
        push_exp(18, 3'b000, 0, 0, 3'd1, 0, "chatter_refilter");
        for (int k = 1; k <= 45; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].k <= k) begin
                e = sb.pop_front();
                tests++;
                if (e.k != k || {stage_rst_n, all_up, lock_lost_sticky, fsm_state} !== {e.stg, e.up, e.sticky, e.st}) begin
                    fails++;
                    $display("FAIL %s @%0d: got stage=%b up=%b sticky=%b state=%0d, want stage=%b up=%b sticky=%b state=%0d",
                             e.name, k, stage_rst_n, all_up, lock_lost_sticky, fsm_state, e.stg, e.up, e.sticky, e.st);
                end
`ifdef LOCK_LOSS_COUNTER_EN
                tests++;
                if (lock_loss_count !== e.cnt[15:0]) begin
                    fails++;
                    $display("FAIL %s_count @%0d: got %0d, want %0d", e.name, k, lock_loss_count, e.cnt);
                end
`endif
            end
            if (k == 2)  rst_n = 1'b1;
            if (k == 4)  pll_lock = 1'b1;
            if (k == 14) pll_lock = 1'b0;
            if (k == 15) begin
                pll_lock = 1'b1;
                push_exp(k + 18, 3'b000, 0, 0, 3'd1, 0, "chatter_pre_release");
                push_exp(k + 19, 3'b001, 0, 0, 3'd2, 0, "chatter_stage0");
                push_exp(k + 27, 3'b111, 0, 0, 3'd3, 0, "chatter_run");
                push_exp(k + 28, 3'b111, 1, 0, 3'd3, 0, "chatter_allup");
            end
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL chatter_timeout: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        pll_lock = 1'b0;
        push_exp(2, 3'b111, 1, 0, 3'd3, 0, "simul_before");
        for (int k = 1; k <= 45; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].k <= k) begin
                e = sb.pop_front();
                tests++;
                if (e.k != k || {stage_rst_n, all_up, lock_lost_sticky, fsm_state} !== {e.stg, e.up, e.sticky, e.st}) begin
                    fails++;
                    $display("FAIL %s @%0d: got stage=%b up=%b sticky=%b state=%0d, want stage=%b up=%b sticky=%b state=%0d",
                             e.name, k, stage_rst_n, all_up, lock_lost_sticky, fsm_state, e.stg, e.up, e.sticky, e.st);
                end
`ifdef LOCK_LOSS_COUNTER_EN
                tests++;
                if (lock_loss_count !== e.cnt[15:0]) begin
                    fails++;
                    $display("FAIL %s_count @%0d: got %0d, want %0d", e.name, k, lock_loss_count, e.cnt);
                end
`endif
            end
            if (k == 2) begin
                sw_reset_req = 1'b1;
                push_exp(3, 3'b000, 0, 1, 3'd0, 1, "simul_loss_beats_swreq");
            end
            if (k == 3) sw_reset_req = 1'b0;
            if (k == 6) begin
                pll_lock = 1'b1;
                push_exp(25, 3'b001, 0, 1, 3'd2, 1, "simul_relock_stage0");
                push_exp(34, 3'b111, 1, 1, 3'd3, 1, "simul_relock_allup");
            end
            if (k == 36) begin
                clear_sticky = 1'b1;
                push_exp(37, 3'b111, 1, 0, 3'd3, 0, "simul_clear");
            end
            if (k == 37) clear_sticky = 1'b0;
            if (k == 40) begin
                pll_lock = 1'b0;
                push_exp(42, 3'b111, 1, 0, 3'd3, 0, "simul_pre_loss");
            end
            if (k == 42) begin
                clear_sticky = 1'b1;
                push_exp(43, 3'b000, 0, 1, 3'd0, 1, "simul_set_beats_clear");
            end
            if (k == 43) clear_sticky = 1'b0;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL simul_timeout: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_midrelease_reset();
        exp_t e;
        pll_lock = 1'b1;
        push_exp(19, 3'b001, 0, 1, 3'd2, 1, "midrel_stage0");
        for (int k = 1; k <= 52; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].k <= k) begin
                e = sb.pop_front();
                tests++;
                if (e.k != k || {stage_rst_n, all_up, lock_lost_sticky, fsm_state} !== {e.stg, e.up, e.sticky, e.st}) begin
                    fails++;
                    $display("FAIL %s @%0d: got stage=%b up=%b sticky=%b state=%0d, want stage=%b up=%b sticky=%b state=%0d",
                             e.name, k, stage_rst_n, all_up, lock_lost_sticky, fsm_state, e.stg, e.up, e.sticky, e.st);
                end
`ifdef LOCK_LOSS_COUNTER_EN
                tests++;
                if (lock_loss_count !== e.cnt[15:0]) begin
                    fails++;
                    $display("FAIL %s_count @%0d: got %0d, want %0d", e.name, k, lock_loss_count, e.cnt);
                end
`endif
            end
            if (k == 20) begin
                rst_n = 1'b0;
                push_exp(21, 3'b000, 0, 0, 3'd0, 0, "midrel_reset_k21");
                push_exp(22, 3'b000, 0, 0, 3'd0, 0, "midrel_reset_k22");
            end
            if (k == 22) begin
                rst_n = 1'b1;
                push_exp(24, 3'b000, 0, 0, 3'd0, 0, "midrel_idle");
                push_exp(25, 3'b000, 0, 0, 3'd1, 0, "midrel_filter");
                push_exp(40, 3'b000, 0, 0, 3'd1, 0, "midrel_pre_release");
                push_exp(41, 3'b001, 0, 0, 3'd2, 0, "midrel_restage0");
                push_exp(49, 3'b111, 0, 0, 3'd3, 0, "midrel_run");
                push_exp(50, 3'b111, 1, 0, 3'd3, 0, "midrel_allup");
            end
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL midrel_timeout: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        pll_lock     = 1'b0;
        sw_reset_req = 1'b0;
        clear_sticky = 1'b0;
        test_reset();
        test_bringup();
        test_sw_reset();
        test_lock_loss();
        test_chatter();
        test_simultaneous();
        test_midrelease_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
